// File: rtl/fetch_pc_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_stage_pkg
// Shared Y86-64 fetch-stage definitions: status codes, icode constants, the
// "no register" id, and the packed layout of the F/D pipeline register along
// with a helper that produces its bubble (nop) value.
// No ports; imported by the fetch-stage RTL.
// -----------------------------------------------------------------------------
package fetch_pc_stage_pkg;

   // Instruction status carried down the pipeline.
   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_t;

   // Y86-64 instruction codes.
   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   // Register id meaning "no register operand".
   localparam logic [3:0] RNONE = 4'hF;

   // F/D pipeline register contents.
   typedef struct packed {
      stat_t       stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valC;
      logic [63:0] valP;
   } dreg_t;

   // A bubble is an AOK nop with no register operands and zero constants,
   // so decode treats it as doing nothing.
   function automatic dreg_t bubbleD();
      dreg_t b;
      b.stat  = STAT_AOK;
      b.icode = ICODE_NOP;
      b.ifun  = 4'h0;
      b.rA    = RNONE;
      b.rB    = RNONE;
      b.valC  = 64'h0;
      b.valP  = 64'h0;
      return b;
   endfunction

endpackage

// File: rtl/fetch_pc_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_stage_if
// Bundles every non-clock/reset signal of the fetch stage.
//   Control in : F_stall, D_stall, D_bubble
//   Redirects  : M_icode, M_Cnd, M_valA (mispredicted jXX), W_icode, W_valM (ret)
//   IMEM       : IMEM_PC out; icode, ifun, rA, rB, valC back in
//   Outputs    : F_predPC, D_stat/D_icode/D_ifun/D_rA/D_rB/D_valC/D_valP, halted
// modport slave  : the fetch stage itself.
// modport master : whatever drives the stage (pipeline control, IMEM, bench).
// -----------------------------------------------------------------------------
interface fetch_pc_stage_if;

   logic        F_stall;
   logic        D_stall;
   logic        D_bubble;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valA;
   logic [3:0]  W_icode;
   logic [63:0] W_valM;

   logic [63:0] IMEM_PC;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic [63:0] valC;

   logic [63:0] F_predPC;
   logic [2:0]  D_stat;
   logic [3:0]  D_icode;
   logic [3:0]  D_ifun;
   logic [3:0]  D_rA;
   logic [3:0]  D_rB;
   logic [63:0] D_valC;
   logic [63:0] D_valP;
   logic        halted;

   modport slave (
      input  F_stall, D_stall, D_bubble,
      input  M_icode, M_Cnd, M_valA, W_icode, W_valM,
      input  icode, ifun, rA, rB, valC,
      output IMEM_PC, F_predPC,
      output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
      output halted
   );

   modport master (
      output F_stall, D_stall, D_bubble,
      output M_icode, M_Cnd, M_valA, W_icode, W_valM,
      output icode, ifun, rA, rB, valC,
      input  IMEM_PC, F_predPC,
      input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
      input  halted
   );

endinterface

// File: rtl/fetch_pc_stage_len_decode.sv
// -----------------------------------------------------------------------------
// fetch_len_decode
// Purely combinational instruction-format decode for the fetch stage.
//   i_icode        in  4  instruction code from instruction memory
//   o_needRegids   out 1  instruction carries a register-specifier byte
//   o_needValC     out 1  instruction carries an 8-byte constant
//   o_instrValid   out 1  icode is a defined Y86-64 instruction
// -----------------------------------------------------------------------------
module fetch_len_decode
   import fetch_pc_stage_pkg::*;
(
   input  logic [3:0] i_icode,
   output logic       o_needRegids,
   output logic       o_needValC,
   output logic       o_instrValid
);

   // Map each icode to its encoding shape. Undefined codes get the shortest
   // shape (a single byte) so the address check only looks at that byte.
   always_comb begin
      o_needRegids = 1'b0;
      o_needValC   = 1'b0;
      o_instrValid = 1'b1;
      case (i_icode)
         ICODE_HALT,
         ICODE_NOP,
         ICODE_RET:    ;
         ICODE_RRMOVQ,
         ICODE_OPQ,
         ICODE_PUSHQ,
         ICODE_POPQ:   o_needRegids = 1'b1;
         ICODE_IRMOVQ,
         ICODE_RMMOVQ,
         ICODE_MRMOVQ: begin
            o_needRegids = 1'b1;
            o_needValC   = 1'b1;
         end
         ICODE_JXX,
         ICODE_CALL:   o_needValC   = 1'b1;
         default:      o_instrValid = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_pc_stage.sv
// -----------------------------------------------------------------------------
// fetch_pc_stage
// Y86-64 fetch stage: owns the predicted-PC register, picks the address to
// fetch from, measures the fetched instruction, predicts the next PC,
// classifies status, and loads the F/D pipeline register.
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high reset
//   bus   slave modport of fetch_pc_stage_if (control, redirects, IMEM
//         request/response, F_predPC, D_* fields, halted)
// Parameters
//   RESET_PC    PC loaded into F_predPC on reset
//   IMEM_BYTES  instruction memory size; any instruction byte at or beyond
//               this address yields ADR status
// -----------------------------------------------------------------------------
module fetch_pc_stage
   import fetch_pc_stage_pkg::*;
#(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          IMEM_BYTES = 2048
)
(
   input  logic             clk,
   input  logic             rst,
   fetch_pc_stage_if.slave  bus
);

   localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

   logic [63:0] r_predPc;
   logic        r_halted;
   dreg_t       r_d;

   logic [63:0] w_fetchPc;
   logic        w_needRegids;
   logic        w_needValC;
   logic        w_instrValid;
   logic [63:0] w_len;
   logic [63:0] w_valP;
   logic [64:0] w_lastByte;
   logic        w_adrFault;
   stat_t       w_stat;
   logic [63:0] w_predPc;
   dreg_t       w_fetched;

   fetch_len_decode u_lenDecode (
      .i_icode      (bus.icode),
      .o_needRegids (w_needRegids),
      .o_needValC   (w_needValC),
      .o_instrValid (w_instrValid)
   );

   // Choose the fetch address. A ret reaching write-back supplies the true
   // return address and is the oldest redirect, so it wins over a jXX in
   // memory that turned out not-taken (which falls through to M_valA).
   always_comb begin
      w_fetchPc = r_predPc;
      if (bus.W_icode == ICODE_RET) begin
         w_fetchPc = bus.W_valM;
      end else if (bus.M_icode == ICODE_JXX && !bus.M_Cnd) begin
         w_fetchPc = bus.M_valA;
      end
   end

   // Instruction length is 1 opcode byte, plus an optional register byte,
   // plus an optional 8-byte constant. valP wraps at 64 bits. The last-byte
   // address is formed one bit wider so a PC near the top of the address
   // space cannot wrap around and look in range.
   always_comb begin
      w_len      = 64'd1 + {63'd0, w_needRegids} + {60'd0, w_needValC, 3'd0};
      w_valP     = w_fetchPc + w_len;
      w_lastByte = {1'b0, w_fetchPc} + {1'b0, w_len} - 65'd1;
      w_adrFault = ({1'b0, w_fetchPc} >= IMEM_LIMIT) || (w_lastByte >= IMEM_LIMIT);
   end

   // Status classification. An address fault is reported in preference to
   // an invalid opcode, because the opcode byte itself may not be real.
   always_comb begin
      w_stat = STAT_AOK;
      if (w_adrFault) begin
         w_stat = STAT_ADR;
      end else if (!w_instrValid) begin
         w_stat = STAT_INS;
      end else if (bus.icode == ICODE_HALT) begin
         w_stat = STAT_HLT;
      end
   end

   // Predict taken for all jumps and calls; everything else falls through.
   // Mispredicts and returns are repaired later through the PC-select mux.
   always_comb begin
      w_predPc = w_valP;
      if (bus.icode == ICODE_JXX || bus.icode == ICODE_CALL) begin
         w_predPc = bus.valC;
      end
   end

   // Assemble what the D register would capture this cycle. Instructions
   // without a register byte report RNONE so decode reads no registers.
   always_comb begin
      w_fetched.stat  = w_stat;
      w_fetched.icode = bus.icode;
      w_fetched.ifun  = bus.ifun;
      w_fetched.rA    = w_needRegids ? bus.rA : RNONE;
      w_fetched.rB    = w_needRegids ? bus.rB : RNONE;
      w_fetched.valC  = bus.valC;
      w_fetched.valP  = w_valP;
   end

   // F register and sticky halt flag. Once a non-AOK instruction has really
   // entered decode (not squashed by stall or bubble) the PC freezes until
   // reset, so nothing past the faulting instruction is ever fetched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_predPc <= RESET_PC;
         r_halted <= 1'b0;
      end else begin
         if (!bus.F_stall && !r_halted) begin
            r_predPc <= w_predPc;
         end
         r_halted <= r_halted | ((w_stat != STAT_AOK) && !bus.D_stall && !bus.D_bubble);
      end
   end

   // F/D pipeline register. A bubble request overrides a stall; after a halt
   // decode is fed bubbles so the faulting instruction is the last one seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_d <= bubbleD();
      end else if (bus.D_bubble) begin
         r_d <= bubbleD();
      end else if (bus.D_stall) begin
         r_d <= r_d;
      end else if (r_halted) begin
         r_d <= bubbleD();
      end else begin
         r_d <= w_fetched;
      end
   end

   // Drive the interface outputs from the registers and the PC mux.
   always_comb begin
      bus.IMEM_PC  = w_fetchPc;
      bus.F_predPC = r_predPc;
      bus.halted   = r_halted;
      bus.D_stat   = r_d.stat;
      bus.D_icode  = r_d.icode;
      bus.D_ifun   = r_d.ifun;
      bus.D_rA     = r_d.rA;
      bus.D_rB     = r_d.rB;
      bus.D_valC   = r_d.valC;
      bus.D_valP   = r_d.valP;
   end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_stage
// Self-checking bench for fetch_pc_stage: directed scenarios for reset, PC
// selection, stall/bubble, halt and error status, then a randomized run
// against a behavioural model built from the instruction-format table.
// -----------------------------------------------------------------------------
module tb_fetch_pc_stage;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   fetch_pc_stage_if ifc();

   fetch_pc_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Quiet all control and redirect inputs.
   task automatic applyStimulus_idle();
      ifc.F_stall  = 1'b0;
      ifc.D_stall  = 1'b0;
      ifc.D_bubble = 1'b0;
      ifc.M_icode  = 4'h1;
      ifc.M_Cnd    = 1'b1;
      ifc.M_valA   = 64'h0;
      ifc.W_icode  = 4'h1;
      ifc.W_valM   = 64'h0;
   endtask

   // Present one instruction from memory.
   task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc);
      ifc.icode = ic;
      ifc.ifun  = fn;
      ifc.rA    = ra;
      ifc.rB    = rb;
      ifc.valC  = vc;
   endtask

   task automatic doReset();
      applyStimulus_idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulus(4'h6, 4'h0, 4'h1, 4'h2, 64'h0);
      doReset();
      total++; if (ifc.F_predPC !== 64'h0) begin bad++; $display("FAIL reset_predPC got=%0h want=0", ifc.F_predPC); end
      total++; if (ifc.D_icode !== 4'h1) begin bad++; $display("FAIL reset_icode got=%0h want=1", ifc.D_icode); end
      total++; if (ifc.D_stat !== 3'd1) begin bad++; $display("FAIL reset_stat got=%0d want=1", ifc.D_stat); end
      total++; if (ifc.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", ifc.halted); end
      total++; if ({ifc.D_rA, ifc.D_rB, ifc.D_valC, ifc.D_valP} !== {4'hF, 4'hF, 64'h0, 64'h0})
         begin bad++; $display("FAIL reset_bubble got=%0h/%0h/%0h/%0h want=F/F/0/0", ifc.D_rA, ifc.D_rB, ifc.D_valC, ifc.D_valP); end
   endtask

   task automatic test_irmovq();
      applyStimulus(4'h3, 4'h0, 4'hF, 4'h2, 64'h10);
      #1;
      total++; if (ifc.IMEM_PC !== 64'h0) begin bad++; $display("FAIL irmovq_imempc got=%0h want=0", ifc.IMEM_PC); end
      tick();
      total++; if (ifc.D_icode !== 4'h3) begin bad++; $display("FAIL irmovq_icode got=%0h want=3", ifc.D_icode); end
      total++; if (ifc.D_rB !== 4'h2) begin bad++; $display("FAIL irmovq_rB got=%0h want=2", ifc.D_rB); end
      total++; if (ifc.D_valC !== 64'h10) begin bad++; $display("FAIL irmovq_valC got=%0h want=10", ifc.D_valC); end
      total++; if (ifc.D_valP !== 64'h0A) begin bad++; $display("FAIL irmovq_valP got=%0h want=a", ifc.D_valP); end
      total++; if (ifc.F_predPC !== 64'h0A) begin bad++; $display("FAIL irmovq_predPC got=%0h want=a", ifc.F_predPC); end
   endtask

   task automatic test_jump_select();
      applyStimulus(4'h7, 4'h0, 4'h3, 4'h4, 64'h40);
      #1;
      total++; if (ifc.IMEM_PC !== 64'h0A) begin bad++; $display("FAIL jmp_imempc got=%0h want=a", ifc.IMEM_PC); end
      tick();
      total++; if (ifc.D_valP !== 64'h13) begin bad++; $display("FAIL jmp_valP got=%0h want=13", ifc.D_valP); end
      total++; if (ifc.F_predPC !== 64'h40) begin bad++; $display("FAIL jmp_predPC got=%0h want=40", ifc.F_predPC); end
      total++; if ({ifc.D_rA, ifc.D_rB} !== 8'hFF) begin bad++; $display("FAIL jmp_noregs got=%0h want=ff", {ifc.D_rA, ifc.D_rB}); end
      ifc.M_icode = 4'h7; ifc.M_Cnd = 1'b1; ifc.M_valA = 64'h13;
      #1;
      total++; if (ifc.IMEM_PC !== 64'h40) begin bad++; $display("FAIL sel_taken got=%0h want=40", ifc.IMEM_PC); end
      ifc.M_Cnd = 1'b0;
      #1;
      total++; if (ifc.IMEM_PC !== 64'h13) begin bad++; $display("FAIL sel_mispredict got=%0h want=13", ifc.IMEM_PC); end
      ifc.W_icode = 4'h9; ifc.W_valM = 64'h80;
      #1;
      total++; if (ifc.IMEM_PC !== 64'h80) begin bad++; $display("FAIL sel_ret got=%0h want=80", ifc.IMEM_PC); end
      applyStimulus_idle();
      #1;
   endtask

   task automatic test_stall_bubble();
      applyStimulus(4'h6, 4'h1, 4'h2, 4'h3, 64'h0);
      ifc.F_stall = 1'b1;
      ifc.D_stall = 1'b1;
      tick();
      tick();
      total++; if (ifc.F_predPC !== 64'h40) begin bad++; $display("FAIL stall_predPC got=%0h want=40", ifc.F_predPC); end
      total++; if ({ifc.D_icode, ifc.D_valP, ifc.D_valC} !== {4'h7, 64'h13, 64'h40})
         begin bad++; $display("FAIL stall_D got=%0h/%0h/%0h want=7/13/40", ifc.D_icode, ifc.D_valP, ifc.D_valC); end
      ifc.D_bubble = 1'b1;
      tick();
      total++; if (ifc.D_icode !== 4'h1) begin bad++; $display("FAIL bubble_icode got=%0h want=1", ifc.D_icode); end
      total++; if (ifc.D_valP !== 64'h0) begin bad++; $display("FAIL bubble_valP got=%0h want=0", ifc.D_valP); end
      total++; if (ifc.F_predPC !== 64'h40) begin bad++; $display("FAIL bubble_predPC got=%0h want=40", ifc.F_predPC); end
      applyStimulus_idle();
   endtask

   task automatic test_halt();
      doReset();
      applyStimulus(4'h7, 4'h0, 4'hF, 4'hF, 64'h20);
      tick();
      applyStimulus(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
      #1;
      total++; if (ifc.IMEM_PC !== 64'h20) begin bad++; $display("FAIL halt_imempc got=%0h want=20", ifc.IMEM_PC); end
      tick();
      total++; if (ifc.D_stat !== 3'd2) begin bad++; $display("FAIL halt_stat got=%0d want=2", ifc.D_stat); end
      total++; if (ifc.halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%0b want=1", ifc.halted); end
      total++; if (ifc.F_predPC !== 64'h21) begin bad++; $display("FAIL halt_predPC got=%0h want=21", ifc.F_predPC); end
      applyStimulus(4'h3, 4'h0, 4'hF, 4'h5, 64'h99);
      tick();
      tick();
      total++; if (ifc.F_predPC !== 64'h21) begin bad++; $display("FAIL halt_frozen got=%0h want=21", ifc.F_predPC); end
      total++; if ({ifc.D_icode, ifc.D_stat} !== {4'h1, 3'd1}) begin bad++; $display("FAIL halt_bubbles got=%0h/%0d want=1/1", ifc.D_icode, ifc.D_stat); end
      ifc.F_stall = 1'b1; ifc.D_stall = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifc.F_stall = 1'b0; ifc.D_stall = 1'b0;
      total++; if ({ifc.F_predPC, ifc.halted, ifc.D_icode} !== {64'h0, 1'b0, 4'h1})
         begin bad++; $display("FAIL halt_reset got=%0h/%0b/%0h want=0/0/1", ifc.F_predPC, ifc.halted, ifc.D_icode); end
      tick();
      total++; if ({ifc.D_icode, ifc.F_predPC} !== {4'h3, 64'h0A}) begin bad++; $display("FAIL halt_resume got=%0h/%0h want=3/a", ifc.D_icode, ifc.F_predPC); end
   endtask

   task automatic test_errors();
      doReset();
      applyStimulus(4'hC, 4'h0, 4'h1, 4'h2, 64'h0);
      tick();
      total++; if (ifc.D_stat !== 3'd4) begin bad++; $display("FAIL err_ins got=%0d want=4", ifc.D_stat); end
      doReset();
      applyStimulus(4'h7, 4'h0, 4'hF, 4'hF, 64'h7FC);
      tick();
      applyStimulus(4'h3, 4'h0, 4'hF, 4'h1, 64'h5);
      tick();
      total++; if (ifc.D_stat !== 3'd3) begin bad++; $display("FAIL err_adr_irmovq got=%0d want=3", ifc.D_stat); end
      doReset();
      applyStimulus(4'h7, 4'h0, 4'hF, 4'hF, 64'h7FF);
      tick();
      applyStimulus(4'h9, 4'h0, 4'hF, 4'hF, 64'h0);
      tick();
      total++; if ({ifc.D_stat, ifc.D_valP} !== {3'd1, 64'h800}) begin bad++; $display("FAIL err_ret_edge got=%0d/%0h want=1/800", ifc.D_stat, ifc.D_valP); end
      total++; if (ifc.halted !== 1'b0) begin bad++; $display("FAIL err_ret_halted got=%0b want=0", ifc.halted); end
      doReset();
      applyStimulus(4'h7, 4'h0, 4'hF, 4'hF, 64'h800);
      tick();
      applyStimulus(4'hD, 4'h0, 4'hF, 4'hF, 64'h0);
      tick();
      total++; if (ifc.D_stat !== 3'd3) begin bad++; $display("FAIL err_adr_over_ins got=%0d want=3", ifc.D_stat); end
   endtask

   // Randomized run against a model driven by the Y86-64 instruction-length
   // table: length 2 or 10 means a register byte is present, 9 or 10 means
   // an 8-byte constant.
   task automatic test_random();
      int          lenTab [16];
      logic [63:0] mPred;
      logic        mHalt;
      logic [2:0]  mStat;
      logic [3:0]  mIcode, mIfun, mRa, mRb;
      logic [63:0] mValC, mValP;
      logic [63:0] sel, vP, pred;
      logic [2:0]  st;
      int          len;
      logic        hasRegs;
      lenTab = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
      doReset();
      mPred = 64'h0; mHalt = 1'b0;
      mStat = 3'd1; mIcode = 4'h1; mIfun = 4'h0; mRa = 4'hF; mRb = 4'hF; mValC = 64'h0; mValP = 64'h0;
      for (int c = 0; c < 600; c++) begin
         rst          = ($urandom_range(0, 49) == 0) || (mHalt && $urandom_range(0, 2) == 0);
         ifc.F_stall  = ($urandom_range(0, 5) == 0);
         ifc.D_stall  = ($urandom_range(0, 5) == 0);
         ifc.D_bubble = ($urandom_range(0, 7) == 0);
         ifc.M_icode  = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
         ifc.M_Cnd    = 1'($urandom_range(0, 1));
         ifc.M_valA   = 64'($urandom_range(0, 2100));
         ifc.W_icode  = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
         ifc.W_valM   = 64'($urandom_range(0, 2100));
         ifc.icode    = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
         ifc.ifun     = 4'($urandom_range(0, 15));
         ifc.rA       = 4'($urandom_range(0, 15));
         ifc.rB       = 4'($urandom_range(0, 15));
         ifc.valC     = ($urandom_range(0, 19) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'($urandom_range(0, 2100));
         #1;
         if (ifc.W_icode == 4'h9) sel = ifc.W_valM;
         else if (ifc.M_icode == 4'h7 && !ifc.M_Cnd) sel = ifc.M_valA;
         else sel = mPred;
         total++; if (ifc.IMEM_PC !== sel) begin bad++; $display("FAIL rand_imempc cyc=%0d got=%0h want=%0h", c, ifc.IMEM_PC, sel); end
         len     = lenTab[ifc.icode];
         hasRegs = (len == 2) || (len == 10);
         vP      = sel + 64'(len);
         if (sel >= 64'd2048 || sel + 64'(len) - 64'd1 >= 64'd2048) st = 3'd3;
         else if (ifc.icode > 4'hB) st = 3'd4;
         else if (ifc.icode == 4'h0) st = 3'd2;
         else st = 3'd1;
         pred = (ifc.icode == 4'h7 || ifc.icode == 4'h8) ? ifc.valC : vP;
         if (rst) begin
            mPred = 64'h0; mHalt = 1'b0;
            mStat = 3'd1; mIcode = 4'h1; mIfun = 4'h0; mRa = 4'hF; mRb = 4'hF; mValC = 64'h0; mValP = 64'h0;
         end else begin
            if (ifc.D_bubble || (!ifc.D_stall && mHalt)) begin
               mStat = 3'd1; mIcode = 4'h1; mIfun = 4'h0; mRa = 4'hF; mRb = 4'hF; mValC = 64'h0; mValP = 64'h0;
            end else if (!ifc.D_stall) begin
               mStat = st; mIcode = ifc.icode; mIfun = ifc.ifun;
               mRa = hasRegs ? ifc.rA : 4'hF; mRb = hasRegs ? ifc.rB : 4'hF;
               mValC = ifc.valC; mValP = vP;
            end
            if (!ifc.F_stall && !mHalt) mPred = pred;
            if (st != 3'd1 && !ifc.D_stall && !ifc.D_bubble) mHalt = 1'b1;
         end
         tick();
         total++; if (ifc.F_predPC !== mPred) begin bad++; $display("FAIL rand_predPC cyc=%0d got=%0h want=%0h", c, ifc.F_predPC, mPred); end
         total++; if (ifc.halted !== mHalt) begin bad++; $display("FAIL rand_halted cyc=%0d got=%0b want=%0b", c, ifc.halted, mHalt); end
         total++;
         if ({ifc.D_stat, ifc.D_icode, ifc.D_ifun, ifc.D_rA, ifc.D_rB, ifc.D_valC, ifc.D_valP} !==
             {mStat, mIcode, mIfun, mRa, mRb, mValC, mValP}) begin
            bad++;
            $display("FAIL rand_D cyc=%0d got=%0d/%0h/%0h/%0h/%0h/%0h/%0h want=%0d/%0h/%0h/%0h/%0h/%0h/%0h", c,
                     ifc.D_stat, ifc.D_icode, ifc.D_ifun, ifc.D_rA, ifc.D_rB, ifc.D_valC, ifc.D_valP,
                     mStat, mIcode, mIfun, mRa, mRb, mValC, mValP);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      applyStimulus_idle();
      applyStimulus(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
      #2;
      test_reset();
      test_irmovq();
      test_jump_select();
      test_stall_bubble();
      test_halt();
      test_errors();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
